// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: ROM address/data, the decode valid/ready slot and the
// branch redirect from execute.
interface instruction_fetch_if;
  logic [7:0] rom_address;
  logic [8:0] rom_instruction;
  logic [8:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [7:0] branch_target;

  modport master (
    output rom_address,
    input  rom_instruction,
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    input  rom_address,
    output rom_instruction,
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output branch_taken,
    output branch_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter and fetch stage for the 9-bit BaLuGa core: drives the ROM,
// holds one fetched word for decode, follows branches and stops on halt.
module instruction_fetch #(
  parameter logic [8:0] HALT_INSTR = 9'b0111_00_010,
  parameter int         CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          start_address,
  instruction_fetch_if.master bus,
  output logic [7:0]          pc_out,
  output logic                halted,
  output logic                pc_wrap,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_reg,  state_next;
  logic [7:0]       pc_reg,     pc_next;
  logic [8:0]       instr_reg,  instr_next;
  logic             valid_reg,  valid_next;
  logic             halted_reg, halted_next;
  logic             wrap_reg,   wrap_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  logic load;
  assign load = (state_reg == FETCH) && (!valid_reg || bus.instr_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      pc_reg     <= 8'd0;
      instr_reg  <= 9'd0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      wrap_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      wrap_reg   <= wrap_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    wrap_next   = wrap_reg;
    count_next  = count_reg;

    if ((state_reg == FETCH || state_reg == DRAIN) && (count_reg != {CNT_W{1'b1}}))
      count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = start_address;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // A redirect flushes the slot even when decode is ready to take it.
        if (bus.branch_taken) begin
          valid_next = 1'b0;
          pc_next    = bus.branch_target;
        end else if (load) begin
          instr_next = bus.rom_instruction;
          valid_next = 1'b1;
          if (bus.rom_instruction == HALT_INSTR) begin
            state_next = DRAIN;
          end else begin
            pc_next = pc_reg + 8'd1;
            if (pc_reg == 8'hFF)
              wrap_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.branch_taken) begin
          valid_next = 1'b0;
          pc_next    = bus.branch_target;
          state_next = FETCH;
        end else if (valid_reg && bus.instr_ready) begin
          valid_next  = 1'b0;
          halted_next = 1'b1;
          state_next  = HALTED;
        end
      end
      HALTED: begin
        if (start) begin
          halted_next = 1'b0;
          wrap_next   = 1'b0;
          count_next  = '0;
          pc_next     = start_address;
          state_next  = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rom_address = pc_reg;
  assign bus.instr_out   = instr_reg;
  assign bus.instr_valid = valid_reg;
  assign pc_out          = pc_reg;
  assign halted          = halted_reg;
  assign pc_wrap         = wrap_reg;
  assign cycle_count     = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the fetch stage kept in this bench.
module tb_instruction_fetch;
  localparam logic [8:0] HALT = 9'b0111_00_010;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_address = 8'd0;
  logic [7:0]  pc_out;
  logic        halted;
  logic        pc_wrap;
  logic [15:0] cycle_count;
  logic [8:0]  rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_if bus();
  assign bus.rom_instruction = rom[bus.rom_address];

  instruction_fetch #(.HALT_INSTR(HALT), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .bus(bus.master), .pc_out(pc_out), .halted(halted), .pc_wrap(pc_wrap),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Reference model: "mode" says what the stage is doing, not how the RTL encodes it.
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT_HALT = 2, M_STOPPED = 3;
  int         m_mode;
  int         m_pc;
  bit         m_valid;
  logic [8:0] m_out;
  bit         m_halted;
  bit         m_wrap;
  int         m_count;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_valid = 0; m_out = 9'd0;
    m_halted = 0; m_wrap = 0; m_count = 0;
  endtask

  task automatic model_step(input bit st, input logic [7:0] sa, input bit rdy,
                            input bit br, input logic [7:0] bt);
    int         mode = m_mode;
    logic [8:0] word = rom[m_pc];
    if ((mode == M_RUN || mode == M_WAIT_HALT) && m_count < 65535)
      m_count = m_count + 1;
    if (mode == M_IDLE && st) begin
      m_pc = int'(sa); m_mode = M_RUN;
    end else if (mode == M_RUN) begin
      if (br) begin
        m_valid = 0; m_pc = int'(bt);
      end else if (!m_valid || rdy) begin
        m_out = word; m_valid = 1;
        if (word == HALT) m_mode = M_WAIT_HALT;
        else begin
          if (m_pc == 255) m_wrap = 1;
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else if (mode == M_WAIT_HALT) begin
      if (br) begin
        m_valid = 0; m_pc = int'(bt); m_mode = M_RUN;
      end else if (m_valid && rdy) begin
        m_valid = 0; m_halted = 1; m_mode = M_STOPPED;
      end
    end else if (mode == M_STOPPED && st) begin
      m_halted = 0; m_wrap = 0; m_count = 0; m_pc = int'(sa); m_mode = M_RUN;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    32'(bus.instr_valid), 32'(m_valid));
    check({tag, ".instr"},    32'(bus.instr_out),   32'(m_out));
    check({tag, ".pc"},       32'(pc_out),          32'(m_pc));
    check({tag, ".rom_addr"}, 32'(bus.rom_address), 32'(m_pc));
    check({tag, ".halted"},   32'(halted),          32'(m_halted));
    check({tag, ".wrap"},     32'(pc_wrap),         32'(m_wrap));
    check({tag, ".count"},    32'(cycle_count),     32'(m_count));
  endtask

  // Called just after a rising edge (or at a falling edge); returns 1 ns after the next rising edge.
  task automatic cycle(input string tag, input bit st, input logic [7:0] sa, input bit rdy,
                       input bit br, input logic [7:0] bt);
    start = st; start_address = sa; bus.instr_ready = rdy;
    bus.branch_taken = br; bus.branch_target = bt;
    model_step(st, sa, rdy, br, bt);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0; start = 1'b0; bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int saved_count;
    bus.instr_ready = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 9'(i) | 9'h100;
    rom[0] = 9'h0A1; rom[1] = 9'h0B2; rom[2] = 9'h0C3; rom[3] = 9'h0D4;
    rom[7] = 9'h077;
    #2;

    // Reset state
    do_reset("reset");
    check("reset_valid",  32'(bus.instr_valid), 32'd0);
    check("reset_rom",    32'(bus.rom_address), 32'd0);
    check("reset_halted", 32'(halted),          32'd0);
    check("reset_count",  32'(cycle_count),     32'd0);
    cycle("idle", 0, 8'd0, 1, 0, 8'd0);

    // Streaming A,B,C,D
    cycle("startA", 1, 8'd0, 1, 0, 8'd0);
    cycle("ldA", 0, 8'd0, 1, 0, 8'd0);  check("outA", 32'(bus.instr_out), 32'h0A1);
    cycle("ldB", 0, 8'd0, 1, 0, 8'd0);  check("outB", 32'(bus.instr_out), 32'h0B2);
    cycle("ldC", 0, 8'd0, 1, 0, 8'd0);  check("outC", 32'(bus.instr_out), 32'h0C3);
    cycle("ldD", 0, 8'd0, 1, 0, 8'd0);  check("outD", 32'(bus.instr_out), 32'h0D4);
    check("pc_after_D", 32'(pc_out), 32'd4);

    // Backpressure on B
    do_reset("rst2");
    cycle("startS", 1, 8'd0, 1, 0, 8'd0);
    cycle("sA", 0, 8'd0, 1, 0, 8'd0);
    cycle("sB", 0, 8'd0, 1, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 0, 8'd0, 0, 0, 8'd0);
      check("stall_out", 32'(bus.instr_out), 32'h0B2);
      check("stall_pc",  32'(pc_out),        32'd2);
    end
    cycle("sC", 0, 8'd0, 1, 0, 8'd0);   check("after_stall", 32'(bus.instr_out), 32'h0C3);

    // Branch while B is valid
    do_reset("rst3");
    cycle("startB", 1, 8'd0, 1, 0, 8'd0);
    cycle("bA", 0, 8'd0, 1, 0, 8'd0);
    cycle("bB", 0, 8'd0, 1, 0, 8'd0);
    cycle("branch", 0, 8'd0, 1, 1, 8'h07);
    check("br_flush", 32'(bus.instr_valid), 32'd0);
    check("br_pc",    32'(pc_out),          32'h07);
    cycle("target", 0, 8'd0, 1, 0, 8'd0);
    check("br_word",  32'(bus.instr_out),   32'h077);
    check("br_valid", 32'(bus.instr_valid), 32'd1);

    // Halt at ROM[5]
    rom[5] = HALT;
    do_reset("rst4");
    cycle("startH", 1, 8'd0, 1, 0, 8'd0);
    for (int i = 0; i < 6; i++) cycle("run", 0, 8'd0, 1, 0, 8'd0);
    check("halt_word", 32'(bus.instr_out), 32'(HALT));
    check("halt_pc",   32'(pc_out),        32'd5);
    cycle("hold1", 0, 8'd0, 0, 0, 8'd0);
    cycle("hold2", 0, 8'd0, 0, 0, 8'd0);
    check("hold_valid", 32'(bus.instr_valid), 32'd1);
    cycle("accept", 0, 8'd0, 1, 0, 8'd0);
    check("halted", 32'(halted), 32'd1);
    check("halted_pc", 32'(pc_out), 32'd5);
    saved_count = m_count;
    cycle("ign_br", 0, 8'd0, 1, 1, 8'h30);
    check("frozen_pc",    32'(pc_out),      32'd5);
    check("frozen_count", 32'(cycle_count), 32'(saved_count));

    // Restart near the top of memory and wrap
    cycle("startW", 1, 8'hFE, 1, 0, 8'd0);
    check("restart_halted", 32'(halted), 32'd0);
    cycle("wFE", 0, 8'd0, 1, 0, 8'd0);  check("outFE", 32'(bus.instr_out), 32'h1FE);
    check("wrap_before", 32'(pc_wrap), 32'd0);
    cycle("wFF", 0, 8'd0, 1, 0, 8'd0);  check("outFF", 32'(bus.instr_out), 32'h1FF);
    check("wrap_after", 32'(pc_wrap), 32'd1);
    cycle("w00", 0, 8'd0, 1, 0, 8'd0);  check("out00", 32'(bus.instr_out), 32'h0A1);

    // Randomized traffic
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 19) == 0) ? HALT : 9'($urandom_range(0, 511));
    do_reset("rst_rand");
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] sa;
      sa = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(252, 255));
      if ($urandom_range(0, 999) < 3)
        do_reset("rand_rst");
      else
        cycle("rand", $urandom_range(0, 9) == 0, sa, $urandom_range(0, 9) < 7,
              $urandom_range(0, 99) < 5, 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
